// File: rtl/wr_port_arbiter8.sv
// Round-robin owner arbitration for one shared register-file write port among 8 requesters.
// One dead cycle separates owners, and a hold limit forcibly revokes long grants.
module wr_port_arbiter8 #(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req,
   input  logic [7:0] done,
   output logic [2:0] grant_idx,
   output logic       grant_en,
   output logic [7:0] grant_oh,
   output logic       timeout
);

   localparam int unsigned N  = 8;
   localparam int unsigned IW = 3;

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t            state;
   logic [IW-1:0]     last;
   logic [CNT_W-1:0]  hold_cnt;
   logic [IW-1:0]     pick_idx;

   // First requester after last, wrapping; the scan ends at last so it has the lowest priority.
   function automatic logic [IW-1:0] pick_next(input logic [N-1:0] r, input logic [IW-1:0] l);
      logic [IW-1:0] cand;
      logic [IW-1:0] sel;
      logic          found;
      sel   = l;
      found = 1'b0;
      for (int k = 1; k <= int'(N); k++) begin
         cand = l + IW'(k);
         if (!found && r[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign pick_idx = pick_next(req, last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         grant_idx <= '0;
         grant_en  <= 1'b0;
         grant_oh  <= '0;
         timeout   <= 1'b0;
         hold_cnt  <= '0;
         last      <= IW'(N - 1);
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               grant_en <= 1'b0;
               grant_oh <= '0;
               if (|req) begin
                  grant_idx <= pick_idx;
                  grant_en  <= 1'b1;
                  grant_oh  <= N'(1) << pick_idx;
                  last      <= pick_idx;
                  hold_cnt  <= CNT_W'(1);
                  state     <= GRANTED;
               end
            end
            GRANTED: begin
               // Release wins over timeout when both land on the same edge.
               if (done[grant_idx] || !req[grant_idx]) begin
                  grant_en <= 1'b0;
                  grant_oh <= '0;
                  state    <= IDLE;
               end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
                  grant_en <= 1'b0;
                  grant_oh <= '0;
                  timeout  <= 1'b1;
                  state    <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant_oh));
   a_oh_match: assert property (@(posedge clk) disable iff (!reset)
      grant_oh == (grant_en ? (N'(1) << grant_idx) : N'(0)));
   a_timeout_fall: assert property (@(posedge clk) disable iff (!reset)
      timeout |-> $fell(grant_en));

endmodule

// File: tb/tb_wr_port_arbiter8.sv
// Self-checking bench for wr_port_arbiter8: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_wr_port_arbiter8;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] req;
   logic [7:0] done;
   logic [2:0] grant_idx;
   logic       grant_en;
   logic [7:0] grant_oh;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   wr_port_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .req(req), .done(done),
      .grant_idx(grant_idx), .grant_en(grant_en), .grant_oh(grant_oh), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      req   = '0;
      done  = '0;
      #3;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (grant_en !== 1'b0 || grant_oh !== 8'h00 || timeout !== 1'b0 || grant_idx !== 3'd0) begin
         errors++;
         $display("FAIL reset_state en=%b oh=%h to=%b idx=%0d want 0/00/0/0", grant_en, grant_oh, timeout, grant_idx);
      end
      req = 8'h40;
      step();
      step();
      checks++;
      if (grant_en !== 1'b1 || grant_idx !== 3'd6) begin
         errors++;
         $display("FAIL pre_reset_grant en=%b idx=%0d want 1/6", grant_en, grant_idx);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (grant_en !== 1'b0 || grant_oh !== 8'h00 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL async_reset en=%b oh=%h to=%b want 0/00/0", grant_en, grant_oh, timeout);
      end
      #2;
      reset = 1'b1;
      req   = 8'hFF;
      step();
      checks++;
      if (grant_en !== 1'b1 || grant_idx !== 3'd0 || grant_oh !== 8'h01) begin
         errors++;
         $display("FAIL reset_first_grant en=%b idx=%0d oh=%h want 1/0/01", grant_en, grant_idx, grant_oh);
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 8'b0010_0000;
      for (int c = 1; c <= 3; c++) begin
         step();
         checks++;
         if (grant_en !== 1'b1 || grant_idx !== 3'd5 || grant_oh !== 8'h20 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle%0d en=%b idx=%0d oh=%h to=%b want 1/5/20/0", c, grant_en, grant_idx, grant_oh, timeout);
         end
      end
      done = 8'h20;
      req  = 8'h00;
      step();
      done = 8'h00;
      checks++;
      if (grant_en !== 1'b0 || grant_oh !== 8'h00 || timeout !== 1'b0 || grant_idx !== 3'd5) begin
         errors++;
         $display("FAIL single_release en=%b oh=%h to=%b idx=%0d want 0/00/0/5", grant_en, grant_oh, timeout, grant_idx);
      end
   endtask

   task automatic test_wrap();
      logic [2:0] exp_seq [4];
      exp_seq = '{3'd0, 3'd7, 3'd0, 3'd7};
      do_reset();
      req = 8'b1000_0001;
      for (int g = 0; g < 4; g++) begin
         step();
         checks++;
         if (grant_en !== 1'b1 || grant_idx !== exp_seq[g]) begin
            errors++;
            $display("FAIL wrap_grant%0d en=%b idx=%0d want 1/%0d", g, grant_en, grant_idx, exp_seq[g]);
         end
         done = 8'h01 << grant_idx;
         step();
         done = 8'h00;
         checks++;
         if (grant_en !== 1'b0) begin
            errors++;
            $display("FAIL wrap_dead%0d en=%b want 0", g, grant_en);
         end
      end
   endtask

   task automatic test_hold();
      do_reset();
      req = 8'h08;
      for (int c = 1; c <= MAX_HOLD; c++) begin
         step();
         checks++;
         if (grant_en !== 1'b1 || grant_idx !== 3'd3 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d en=%b idx=%0d to=%b want 1/3/0", c, grant_en, grant_idx, timeout);
         end
      end
      step();
      checks++;
      if (grant_en !== 1'b0 || timeout !== 1'b1) begin
         errors++;
         $display("FAIL hold_timeout en=%b to=%b want 0/1", grant_en, timeout);
      end
      step();
      checks++;
      if (grant_en !== 1'b1 || grant_idx !== 3'd3 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL hold_regrant en=%b idx=%0d to=%b want 1/3/0", grant_en, grant_idx, timeout);
      end
   endtask

   task automatic test_collision();
      do_reset();
      req = 8'h08;
      for (int c = 1; c <= MAX_HOLD; c++) step();
      done = 8'h08;
      step();
      done = 8'h00;
      checks++;
      if (grant_en !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL collision en=%b to=%b want 0/0", grant_en, timeout);
      end
   endtask

   task automatic test_foreign();
      do_reset();
      req = 8'h04;
      step();
      req  = 8'h17;
      done = 8'h10;
      step();
      done = 8'h00;
      checks++;
      if (grant_en !== 1'b1 || grant_idx !== 3'd2) begin
         errors++;
         $display("FAIL foreign_done en=%b idx=%0d want 1/2", grant_en, grant_idx);
      end
      req = 8'h13;
      step();
      checks++;
      if (grant_en !== 1'b0) begin
         errors++;
         $display("FAIL req_drop en=%b want 0", grant_en);
      end
      step();
      checks++;
      if (grant_en !== 1'b1 || grant_idx !== 3'd4) begin
         errors++;
         $display("FAIL after_drop en=%b idx=%0d want 1/4", grant_en, grant_idx);
      end
   endtask

   // Model: owner index or -1, last winner, cycles held; updated once per edge from sampled inputs.
   task automatic test_random();
      int m_owner, m_last, m_held, m_idx;
      bit m_to;
      logic [7:0] r, d, exp_oh;
      do_reset();
      m_owner = -1; m_last = 7; m_held = 0; m_idx = 0; m_to = 0;
      for (int n = 0; n < 400; n++) begin
         r = 8'($urandom) & 8'($urandom) & 8'($urandom);
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         req  = r;
         done = d;
         m_to = 0;
         if (m_owner < 0) begin
            for (int k = 1; k <= 8; k++) begin
               if (m_owner < 0 && r[(m_last + k) % 8]) begin
                  m_owner = (m_last + k) % 8;
                  m_last  = m_owner;
                  m_idx   = m_owner;
                  m_held  = 1;
               end
            end
         end else if (d[m_owner] || !r[m_owner]) begin
            m_owner = -1;
         end else if (m_held == MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1;
         end else begin
            m_held++;
         end
         step();
         exp_oh = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
         checks++;
         if (grant_en !== (m_owner >= 0) || grant_idx !== 3'(m_idx) || grant_oh !== exp_oh || timeout !== m_to) begin
            errors++;
            $display("FAIL random_cycle%0d en=%b idx=%0d oh=%h to=%b want %b/%0d/%h/%b",
                     n, grant_en, grant_idx, grant_oh, timeout, (m_owner >= 0), m_idx, exp_oh, m_to);
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      req   = '0;
      done  = '0;
      test_reset();
      test_single();
      test_wrap();
      test_hold();
      test_collision();
      test_foreign();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
